// File: rtl/instr_encoder.sv
// Instruction encoder: packs RV32-style fields into 32-bit words and streams
// them into an instruction memory as a program image starting at word 0.
module instr_encoder #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          finish,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    fmt,
    input  logic [6:0]    op,
    input  logic [2:0]    f3,
    input  logic          f7,
    input  logic [4:0]    rd,
    input  logic [4:0]    rs1,
    input  logic [4:0]    rs2,
    input  logic [31:0]   imm,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [AW:0]   count,
    output logic          done,
    output logic          err
);

    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [31:0]   enc;
    logic          legal;
    logic          accept;
    logic [CW-1:0] count_inc;

    // Field packing per format; illegal formats flag legal=0 and encode nothing.
    always_comb begin
        enc   = 32'h0;
        legal = 1'b1;
        case (fmt)
            3'd0: enc = {1'b0, f7, 5'b00000, rs2, rs1, f3, rd, op};
            3'd1: enc = {imm[11:0], rs1, f3, rd, op};
            3'd2: enc = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            3'd3: enc = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            3'd4: enc = {imm[31:12], rd, op};
            3'd5: enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: legal = 1'b0;
        endcase
    end

    // Handshake qualifier and next word count.
    always_comb begin
        accept    = in_valid && in_ready && (state == RUN);
        count_inc = count + CW'(1);
    end

    // Control FSM and registered outputs. The write pointer is count's low
    // bits: both start at 0 and advance together on every legal accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            count     <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= RUN;
                        count    <= '0;
                        err      <= 1'b0;
                        in_ready <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                RUN: begin
                    if (start) begin
                        // Restart drops any same-cycle offer; an already
                        // registered write has left on mem_we this cycle.
                        count    <= '0;
                        err      <= 1'b0;
                        in_ready <= 1'b1;
                    end else begin
                        if (accept && legal) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= count[AW-1:0];
                            mem_wdata <= enc;
                            count     <= count_inc;
                        end
                        if (accept && !legal) begin
                            err <= 1'b1;
                        end
                        if (finish || (accept && legal && (count_inc == DEPTH_W))) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            in_ready <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a default-depth instance and a DEPTH=4
// instance share the same stimulus.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset, start, finish, in_valid;
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;

    logic        in_ready, mem_we, done, err;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [6:0]  count;

    logic        s_in_ready, s_mem_we, s_done, s_err;
    logic [1:0]  s_mem_addr;
    logic [31:0] s_mem_wdata;
    logic [2:0]  s_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(64), .AW(6)) dut (
        .clk(clk), .reset(reset), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .op(op),
        .f3(f3), .f7(f7), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .done(done), .err(err)
    );

    instr_encoder #(.DEPTH(4), .AW(2)) dut_s (
        .clk(clk), .reset(reset), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(s_in_ready), .fmt(fmt), .op(op),
        .f3(f3), .f7(f7), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .count(s_count), .done(s_done), .err(s_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [2:0] f, input logic [6:0] o, input logic [2:0] fn3,
                             input logic fn7, input logic [4:0] d, input logic [4:0] s1,
                             input logic [4:0] s2, input logic [31:0] im);
        fmt = f; op = o; f3 = fn3; f7 = fn7; rd = d; rs1 = s1; rs2 = s2; imm = im;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        set_instr(3'd0, 7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        step(); step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we",   32'(mem_we),   32'd0);
        check("rst_addr",     32'(mem_addr), 32'd0);
        check("rst_wdata",    mem_wdata,     32'd0);
        check("rst_count",    32'(count),    32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_err",      32'(err),      32'd0);

        // Open image, one I-type word.
        reset = 1'b0; start = 1'b1; step(); start = 1'b0;
        check("start_ready", 32'(in_ready), 32'd1);
        check("start_done",  32'(done),     32'd0);
        set_instr(3'd1, 7'b0010011, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        in_valid = 1'b1; step(); in_valid = 1'b0;
        check("i_we",    32'(mem_we),   32'd1);
        check("i_addr",  32'(mem_addr), 32'd0);
        check("i_wdata", mem_wdata,     32'h00500093);
        check("i_count", 32'(count),    32'd1);
        step();
        check("i_we_drop", 32'(mem_we), 32'd0);

        // Restart, then back-to-back R, S, J, B, U.
        start = 1'b1; step(); start = 1'b0;
        check("restart_count", 32'(count), 32'd0);
        in_valid = 1'b1;
        set_instr(3'd0, 7'b0110011, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0); step();
        check("r0_we",    32'(mem_we),   32'd1);
        check("r0_addr",  32'(mem_addr), 32'd0);
        check("r0_wdata", mem_wdata,     32'h002081B3);
        set_instr(3'd0, 7'b0110011, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0); step();
        check("r1_addr",  32'(mem_addr), 32'd1);
        check("r1_wdata", mem_wdata,     32'h402081B3);
        set_instr(3'd2, 7'b0100011, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8); step();
        check("s_addr",  32'(mem_addr), 32'd2);
        check("s_wdata", mem_wdata,     32'h0020A423);
        set_instr(3'd5, 7'b1101111, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8); step();
        check("j_addr",  32'(mem_addr), 32'd3);
        check("j_wdata", mem_wdata,     32'h008000EF);
        set_instr(3'd3, 7'b1100011, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd16); step();
        check("b_addr",  32'(mem_addr), 32'd4);
        check("b_wdata", mem_wdata,     32'h00208863);
        set_instr(3'd4, 7'b0110111, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000); step();
        check("u_addr",  32'(mem_addr), 32'd5);
        check("u_wdata", mem_wdata,     32'h123452B7);
        check("u_we",    32'(mem_we),   32'd1);
        check("u_count", 32'(count),    32'd6);

        // Illegal format: err, no write, then next legal word at unchanged address.
        set_instr(3'd7, 7'b0010011, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5); step();
        check("ill_err",   32'(err),    32'd1);
        check("ill_we",    32'(mem_we), 32'd0);
        check("ill_count", 32'(count),  32'd6);
        set_instr(3'd1, 7'b0010011, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'hFFFFF801); step();
        in_valid = 1'b0;
        check("post_ill_we",    32'(mem_we),   32'd1);
        check("post_ill_addr",  32'(mem_addr), 32'd6);
        check("post_ill_wdata", mem_wdata,     32'h80100113);
        check("post_ill_err",   32'(err),      32'd1);

        // Close with finish; input in DONE is ignored.
        finish = 1'b1; step(); finish = 1'b0;
        check("fin_done",  32'(done),     32'd1);
        check("fin_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1; step(); in_valid = 1'b0;
        check("done_iv_we",    32'(mem_we), 32'd0);
        check("done_iv_count", 32'(count),  32'd7);

        // Fill the DEPTH=4 instance with in_valid held high.
        start = 1'b1; step(); start = 1'b0;
        check("reopen_err", 32'(err), 32'd0);
        set_instr(3'd1, 7'b0010011, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("full_we%0d", i),   32'(s_mem_we),   32'd1);
            check($sformatf("full_addr%0d", i), 32'(s_mem_addr), 32'(i));
        end
        check("full_ready", 32'(s_in_ready), 32'd0);
        check("full_done",  32'(s_done),     32'd1);
        check("full_count", 32'(s_count),    32'd4);
        step();
        check("full_no_we", 32'(s_mem_we),   32'd0);
        check("full_hold",  32'(s_count),    32'd4);

        // Finish together with accept: word still written (big instance, count 5).
        finish = 1'b1; step(); finish = 1'b0; in_valid = 1'b0;
        check("finacc_we",   32'(mem_we),   32'd1);
        check("finacc_addr", 32'(mem_addr), 32'd5);
        check("finacc_done", 32'(done),     32'd1);

        // Reset mid-stream with an offer pending; reset beats start.
        start = 1'b1; step(); start = 1'b0;
        in_valid = 1'b1; step();
        check("pre_rst_we", 32'(mem_we), 32'd1);
        reset = 1'b1; start = 1'b1; step(); start = 1'b0; reset = 1'b0;
        check("rst2_we",    32'(mem_we),    32'd0);
        check("rst2_addr",  32'(mem_addr),  32'd0);
        check("rst2_wdata", mem_wdata,      32'd0);
        check("rst2_count", 32'(count),     32'd0);
        check("rst2_ready", 32'(in_ready),  32'd0);
        step();
        check("rst2_idle_we",    32'(mem_we),   32'd0);
        check("rst2_idle_ready", 32'(in_ready), 32'd0);
        check("rst2_idle_done",  32'(done),     32'd0);
        in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter DEPTH, default 64: instruction-memory capacity in words; power of two, 2..256.
REQ-002 Parameter AW, default 6: address width, SHALL equal log2(DEPTH).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  pulse; (re)opens a program image at word 0.
REQ-006 finish  in  1  pulse; closes the current image.
REQ-007 in_valid  in  1  instruction fields valid.
REQ-008 in_ready  out  1  encoder can accept fields this cycle.
REQ-009 fmt  in  3  format: 000 R, 001 I, 010 S, 011 B, 100 U, 101 J; 110/111 illegal.
REQ-010 op  in  7  opcode field; f3  in  3  funct3; f7  in  1  funct7 bit 5.
REQ-011 rd, rs1, rs2  in  5 each  register indices.
REQ-012 imm  in  32  immediate, already sign-extended / aligned by source.
REQ-013 mem_we  out  1  instruction-memory write strobe.
REQ-014 mem_addr  out  AW  word address of write.
REQ-015 mem_wdata  out  32  encoded instruction word.
REQ-016 count  out  AW+1  words written in current image.
REQ-017 done  out  1  image closed (finish or full).
REQ-018 err  out  1  sticky: an illegal fmt was presented.

Function
REQ-019 States: IDLE, RUN, DONE; in_ready SHALL be 1 only in RUN with count+pending < DEPTH.
REQ-020 IDLE -> RUN on start; DONE -> RUN on start; both clear count, write pointer and err.
REQ-021 RUN -> DONE on finish, or on the accept that makes count+pending == DEPTH; finish and accept in the same cycle: the accepted word is still written.
REQ-022 Accept = in_valid && in_ready; encoded word registered on accept; mem_we=1 exactly the following cycle with mem_addr = write pointer; pointer and count increment in that cycle.
REQ-023 Throughput one instruction per cycle; back-to-back accepts SHALL produce consecutive addresses with no gap.
REQ-024 Encoding, MSB..LSB: R {0,f7,00000,rs2,rs1,f3,rd,op}; I {imm[11:0],rs1,f3,rd,op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; U {imm[31:12],rd,op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
REQ-025 Unused immediate bits SHALL be ignored without error.
REQ-026 Illegal fmt accepted in RUN: err set, no write, count unchanged.
REQ-027 in_valid outside RUN SHALL be ignored; no write, no err.
REQ-028 start during RUN SHALL restart the image at 0; a write pending from the previous cycle still completes at its old address.
REQ-029 done=1 in DONE only; mem_we never asserted in IDLE except to complete a pending write.
REQ-030 count SHALL saturate at DEPTH; mem_addr wraps never occur.

Reset
REQ-031 On reset: state IDLE, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, count 0, done 0, err 0, pending write discarded.
REQ-032 reset SHALL dominate start, finish and in_valid in the same cycle.

Verification
REQ-033 start, then I op=0010011 f3=0 rd=1 rs1=0 imm=5 -> next cycle mem_we=1, addr 0, wdata 0x00500093, count 1.
REQ-034 Back-to-back R add x3,x1,x2 (op 0110011, f7=0) then f7=1 -> addr 0 wdata 0x002081B3, addr 1 wdata 0x402081B3.
REQ-035 S sw x2,8(x1) -> 0x0020A423; J jal x1,8 (op 1101111) -> 0x008000EF.
REQ-036 DEPTH=4, in_valid held high -> exactly 4 writes, addresses 0..3, in_ready 0 after 4th accept, done=1, count 4.
REQ-037 fmt=111 with in_valid -> err=1, no mem_we; next legal instruction written at unchanged address.
REQ-038 reset asserted mid-stream with accept pending -> no write next cycle, all outputs at reset values, in_ready 0 until start.
